// File: rtl/pjon_obi_mgr_buffer_pkg.sv
// ============================================================================
// Module : pjon_obi_mgr_buffer_pkg
// Brief  : Default Croc OBI request/response structs for the PJON manager buffer
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pjon_obi_mgr_buffer_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 1;

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
        logic                      a_optional;
    } pjon_obi_a_chan_t;

    typedef struct packed {
        logic             req;
        pjon_obi_a_chan_t a;
    } pjon_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
        logic                    r_optional;
    } pjon_obi_r_chan_t;

    typedef struct packed {
        logic             gnt;
        logic             rvalid;
        pjon_obi_r_chan_t r;
    } pjon_obi_rsp_t;

endpackage

`default_nettype wire

// File: rtl/pjon_obi_id_fifo.sv
// ============================================================================
// Module : pjon_obi_id_fifo
// Brief  : In-order ID FIFO; a pop frees its slot for a same-cycle push at full
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pjon_obi_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned FillW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (fill_q == '0);
    assign full_o    = (fill_q == FillW'(Depth));
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign head_o    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = w_do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fill_d   = fill_q;
        if (w_do_push && !w_do_pop) begin
            fill_d = fill_q + FillW'(1);
        end else if (!w_do_push && w_do_pop) begin
            fill_d = fill_q - FillW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !pop_i));
`endif

endmodule

`default_nettype wire

// File: rtl/pjon_obi_mgr_buffer.sv
// ============================================================================
// Module : pjon_obi_mgr_buffer
// Brief  : PJON DMA manager-side OBI buffer: A-channel cut, outstanding cap,
//          rid restoration and busy/spurious status
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pjon_obi_mgr_buffer
    import pjon_obi_mgr_buffer_pkg::*;
#(
    parameter int unsigned MaxTrans  = 2,
    parameter int unsigned IdWidth   = 1,
    parameter type         obi_req_t = pjon_obi_req_t,
    parameter type         obi_rsp_t = pjon_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t sbr_req_i,
    output obi_rsp_t sbr_rsp_o,
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i,
    output logic     busy_o,
    output logic     spurious_o
);

    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic               a_full_q, a_full_d;
    obi_req_t           a_q, a_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic               w_dn_hs;
    logic               w_up_hs;
    logic               w_room;
    logic               w_sbr_gnt;
    logic               w_tracked;
    logic               w_cnt_nz;
    logic [IdWidth-1:0] w_head;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    assign w_cnt_nz  = (cnt_q != '0);
    assign w_dn_hs   = a_full_q & mgr_rsp_i.gnt;
    // The entry parked in the register already counts against the cap.
    assign w_room    = ((CntW + 1)'(cnt_q) + (CntW + 1)'(a_full_q)) < (CntW + 1)'(MaxTrans);
    assign w_sbr_gnt = ~rst_i & w_room & (~a_full_q | w_dn_hs);
    assign w_up_hs   = sbr_req_i.req & w_sbr_gnt;
    assign w_tracked = mgr_rsp_i.rvalid & w_cnt_nz;

    always_comb begin
        a_full_d = a_full_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        if (w_up_hs) begin
            a_full_d = 1'b1;
            a_d      = sbr_req_i;
        end else if (w_dn_hs) begin
            a_full_d = 1'b0;
        end
        if (w_dn_hs && !w_tracked) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!w_dn_hs && w_tracked) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_full_q <= 1'b0;
            a_q      <= '0;
            cnt_q    <= '0;
        end else begin
            a_full_q <= a_full_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
        end
    end

    pjon_obi_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_dn_hs),
        .data_i  (a_q.a.aid),
        .pop_i   (w_tracked),
        .head_o  (w_head),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    always_comb begin
        mgr_req_o     = a_q;
        mgr_req_o.req = a_full_q & ~rst_i;
    end

    // R channel has no backpressure; only gnt and rid are substituted.
    always_comb begin
        sbr_rsp_o        = mgr_rsp_i;
        sbr_rsp_o.gnt    = w_sbr_gnt;
        sbr_rsp_o.rvalid = mgr_rsp_i.rvalid & ~rst_i;
        sbr_rsp_o.r.rid  = w_cnt_nz ? w_head : '0;
    end

    assign busy_o     = ~rst_i & (a_full_q | w_cnt_nz);
    assign spurious_o = ~rst_i & mgr_rsp_i.rvalid & ~w_cnt_nz;

`ifndef SYNTHESIS
    a_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (mgr_req_o.req && !mgr_rsp_i.gnt) |=> $stable(mgr_req_o.a));
    a_cnt_cap: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= CntW'(MaxTrans));
    a_cnt_fifo: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_cnt_nz != w_fifo_empty) && (w_fifo_full == (cnt_q == CntW'(MaxTrans))));
`endif

endmodule

`default_nettype wire

// File: tb/tb_pjon_obi_mgr_buffer.sv
// ============================================================================
// Module : tb_pjon_obi_mgr_buffer
// Brief  : Directed self-checking bench with a queue-based reference model
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pjon_obi_mgr_buffer;
    import pjon_obi_mgr_buffer_pkg::*;

    localparam int MT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    pjon_obi_req_t sbr_req;
    pjon_obi_rsp_t sbr_rsp;
    pjon_obi_req_t mgr_req;
    pjon_obi_rsp_t mgr_rsp;
    logic          busy;
    logic          spurious;

    int checks   = 0;
    int failures = 0;

    pjon_obi_mgr_buffer #(
        .MaxTrans (MT),
        .IdWidth  (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sbr_req_i  (sbr_req),
        .sbr_rsp_o  (sbr_rsp),
        .mgr_req_o  (mgr_req),
        .mgr_rsp_i  (mgr_rsp),
        .busy_o     (busy),
        .spurious_o (spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a one-slot holding register plus a queue of in-flight IDs.
    bit            m_full = 1'b0;
    pjon_obi_req_t m_reg;
    logic          m_ids[$];

    always @(negedge clk) begin : cmp
        bit e_gnt;
        bit dnhs;
        int n;
        n     = m_ids.size();
        e_gnt = !rst && ((n + int'(m_full)) < MT) && (!m_full || mgr_rsp.gnt);
        chk("sbr_gnt", sbr_rsp.gnt, e_gnt);
        chk("mgr_req", mgr_req.req, !rst && m_full);
        if (!rst && m_full) chk("mgr_a", mgr_req.a, m_reg.a);
        chk("sbr_rvalid", sbr_rsp.rvalid, !rst && mgr_rsp.rvalid);
        if (!rst && mgr_rsp.rvalid) begin
            chk("sbr_rid", sbr_rsp.r.rid, (n > 0) ? m_ids[0] : 1'b0);
            chk("sbr_rdata", sbr_rsp.r.rdata, mgr_rsp.r.rdata);
            chk("sbr_err", sbr_rsp.r.err, mgr_rsp.r.err);
        end
        chk("spurious", spurious, !rst && mgr_rsp.rvalid && (n == 0));
        chk("busy", busy, !rst && (m_full || (n != 0)));
        if (rst) begin
            m_full = 1'b0;
            m_ids.delete();
        end else begin
            dnhs = m_full && mgr_rsp.gnt;
            if (mgr_rsp.rvalid && (n > 0)) void'(m_ids.pop_front());
            if (dnhs) m_ids.push_back(m_reg.a.aid);
            if (sbr_req.req && e_gnt) begin
                m_full = 1'b1;
                m_reg  = sbr_req;
            end else if (dnhs) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        sbr_req = '0;
        mgr_rsp = '0;
        m_reg   = '0;

        // Reset state
        repeat (2) cyc();
        chk("rst_gnt", sbr_rsp.gnt, 1'b0);
        chk("rst_mreq", mgr_req.req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cyc();

        // 1: single read, aid=1
        sbr_req.req = 1'b1; sbr_req.a.aid = 1'b1; sbr_req.a.addr = 32'h0000_0100;
        #1 chk("t1_gnt_t0", sbr_rsp.gnt, 1'b1);
        chk("t1_mreq_t0", mgr_req.req, 1'b0);
        cyc(); sbr_req.req = 1'b0; mgr_rsp.gnt = 1'b1;
        #1 chk("t1_mreq_t1", mgr_req.req, 1'b1);
        chk("t1_aid_t1", mgr_req.a.aid, 1'b1);
        cyc(); mgr_rsp.gnt = 1'b0;
        #1 chk("t1_busy_t2", busy, 1'b1);
        cyc(); mgr_rsp.rvalid = 1'b1; mgr_rsp.r.rid = 1'b0; mgr_rsp.r.rdata = 32'h1234_5678;
        #1 chk("t1_rvalid_t3", sbr_rsp.rvalid, 1'b1);
        chk("t1_rid_t3", sbr_rsp.r.rid, 1'b1);
        cyc(); mgr_rsp.rvalid = 1'b0;
        #1 chk("t1_busy_t4", busy, 1'b0);
        cyc();

        // 2: cap at MaxTrans, aids 0,1,1
        sbr_req.req = 1'b1; sbr_req.a.aid = 1'b0; mgr_rsp.gnt = 1'b1;
        #1 chk("t2_gnt_a0", sbr_rsp.gnt, 1'b1);
        cyc(); sbr_req.a.aid = 1'b1;
        #1 chk("t2_gnt_a1", sbr_rsp.gnt, 1'b1);
        cyc();
        #1 chk("t2_gnt_full_reg", sbr_rsp.gnt, 1'b0);
        cyc();
        #1 chk("t2_gnt_cnt2", sbr_rsp.gnt, 1'b0);
        chk("t2_mreq_cnt2", mgr_req.req, 1'b0);
        cyc();
        #1 chk("t2_gnt_wait", sbr_rsp.gnt, 1'b0);
        cyc(); mgr_rsp.rvalid = 1'b1; mgr_rsp.r.rid = 1'b0;
        #1 chk("t2_gnt_rv", sbr_rsp.gnt, 1'b0);
        chk("t2_rid0", sbr_rsp.r.rid, 1'b0);
        cyc(); mgr_rsp.rvalid = 1'b0;
        #1 chk("t2_gnt_after_rv", sbr_rsp.gnt, 1'b1);
        cyc(); sbr_req.req = 1'b0;
        #1 chk("t2_mreq_third", mgr_req.req, 1'b1);
        chk("t2_aid_third", mgr_req.a.aid, 1'b1);
        cyc(); mgr_rsp.gnt = 1'b0; mgr_rsp.rvalid = 1'b1;
        #1 chk("t2_rid1a", sbr_rsp.r.rid, 1'b1);
        cyc();
        #1 chk("t2_rid1b", sbr_rsp.r.rid, 1'b1);
        cyc(); mgr_rsp.rvalid = 1'b0;
        #1 chk("t2_busy_end", busy, 1'b0);
        cyc();

        // 3: downstream stall with a write
        sbr_req.req = 1'b1; sbr_req.a.we = 1'b1; sbr_req.a.addr = 32'h1000_0040;
        sbr_req.a.be = 4'hF; sbr_req.a.wdata = 32'hA5A5_5A5A; sbr_req.a.aid = 1'b0;
        #1 chk("t3_gnt_t0", sbr_rsp.gnt, 1'b1);
        cyc(); sbr_req.a.addr = 32'hDEAD_0000; sbr_req.a.wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_addr", mgr_req.a.addr, 32'h1000_0040);
            chk("t3_wdata", mgr_req.a.wdata, 32'hA5A5_5A5A);
            chk("t3_be", mgr_req.a.be, 4'hF);
            chk("t3_sbr_gnt", sbr_rsp.gnt, 1'b0);
            cyc();
        end
        sbr_req.req = 1'b0; mgr_rsp.gnt = 1'b1;
        #1 chk("t3_mreq_release", mgr_req.req, 1'b1);
        cyc(); mgr_rsp.gnt = 1'b0; mgr_rsp.rvalid = 1'b1;
        #1 chk("t3_rid", sbr_rsp.r.rid, 1'b0);
        cyc(); mgr_rsp.rvalid = 1'b0; sbr_req.a.we = 1'b0;
        #1 chk("t3_busy_end", busy, 1'b0);
        cyc();

        // 4: dn_hs and rvalid together at cnt=1, rids 0,1,0
        sbr_req.req = 1'b1; sbr_req.a.aid = 1'b0; sbr_req.a.addr = 32'h0000_0200;
        mgr_rsp.gnt = 1'b1;
        #1 chk("t4_gnt_a", sbr_rsp.gnt, 1'b1);
        cyc(); sbr_req.a.aid = 1'b1;
        #1 chk("t4_gnt_b", sbr_rsp.gnt, 1'b1);
        cyc(); sbr_req.a.aid = 1'b0; mgr_rsp.rvalid = 1'b1;
        #1 chk("t4_rid_0", sbr_rsp.r.rid, 1'b0);
        chk("t4_gnt_cap", sbr_rsp.gnt, 1'b0);
        cyc(); mgr_rsp.rvalid = 1'b0;
        #1 chk("t4_gnt_c", sbr_rsp.gnt, 1'b1);
        chk("t4_busy_cnt1", busy, 1'b1);
        cyc(); sbr_req.req = 1'b0; mgr_rsp.rvalid = 1'b1;
        #1 chk("t4_rid_1", sbr_rsp.r.rid, 1'b1);
        cyc(); mgr_rsp.gnt = 1'b0;
        #1 chk("t4_rid_2", sbr_rsp.r.rid, 1'b0);
        cyc(); mgr_rsp.rvalid = 1'b0;
        #1 chk("t4_busy_end", busy, 1'b0);
        cyc();

        // 5: spurious response at cnt=0
        mgr_rsp.rvalid = 1'b1; mgr_rsp.r.rid = 1'b1; mgr_rsp.r.rdata = 32'h0000_BEEF;
        #1 chk("t5_spur", spurious, 1'b1);
        chk("t5_rvalid", sbr_rsp.rvalid, 1'b1);
        chk("t5_rid", sbr_rsp.r.rid, 1'b0);
        chk("t5_rdata", sbr_rsp.r.rdata, 32'h0000_BEEF);
        cyc(); mgr_rsp.rvalid = 1'b0; mgr_rsp.r.rid = 1'b0;
        #1 chk("t5_spur_off", spurious, 1'b0);
        chk("t5_busy", busy, 1'b0);
        cyc();

        // 6: reset with two outstanding
        sbr_req.req = 1'b1; sbr_req.a.aid = 1'b1; mgr_rsp.gnt = 1'b1;
        cyc(); sbr_req.a.aid = 1'b0;
        cyc(); sbr_req.req = 1'b0;
        cyc(); mgr_rsp.gnt = 1'b0;
        #1 chk("t6_busy_pre", busy, 1'b1);
        chk("t6_gnt_pre", sbr_rsp.gnt, 1'b0);
        rst = 1'b1;
        cyc();
        chk("t6_gnt_rst", sbr_rsp.gnt, 1'b0);
        chk("t6_rvalid_rst", sbr_rsp.rvalid, 1'b0);
        chk("t6_mreq_rst", mgr_req.req, 1'b0);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_spur_rst", spurious, 1'b0);
        rst = 1'b0;
        cyc(); mgr_rsp.rvalid = 1'b1;
        #1 chk("t6_spur_late0", spurious, 1'b1);
        chk("t6_rid_late0", sbr_rsp.r.rid, 1'b0);
        cyc();
        #1 chk("t6_spur_late1", spurious, 1'b1);
        cyc(); mgr_rsp.rvalid = 1'b0;
        #1 chk("t6_spur_off", spurious, 1'b0);
        chk("t6_busy_end", busy, 1'b0);
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
